// File: rtl/abfn_uart_1_tx.sv
// UART transmitter: one-word holding register feeding a start/data/parity/stop
// serialiser with a registered, glitch-free TXD and back-to-back frame support.
module abfn_uart_1_tx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  output logic                 TXD,
  output logic                 TX_BUSY,
  output logic [2:0]           dbg_state
);

  localparam int DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("abfn_uart_1_tx: DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_data_bits_check
    $error("abfn_uart_1_tx: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_parity_check
    $error("abfn_uart_1_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_bits_check
    $error("abfn_uart_1_tx: STOP_BITS must be 1 or 2");
  end

  // Encoding is visible on dbg_state: 0 idle, 1 start, 2 data, 3 parity, 4 stop.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] hold, hold_n;
  logic                 hold_full, hold_full_n;
  logic                 txd_q, txd_n;
  logic                 par, par_n;
  logic                 tick;
  logic                 accept;

  // Parity bit value to put on the line for a given word.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~(^w) : (^w);
  endfunction

  // Handshake: a word transfers on a rising CLK edge where TX_VALID and
  // TX_READY are both high; TX_READY is high exactly when the holding register
  // is empty, and TX_DATA is ignored on every other edge.
  assign accept   = TX_VALID & ~hold_full;
  assign tick     = (cnt == CNT_LAST);
  assign TX_READY = ~hold_full;
  assign TX_BUSY  = (state != ST_IDLE) | hold_full;
  assign TXD      = txd_q;
  assign dbg_state = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      txd_q     <= 1'b1;
      par       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      txd_q     <= txd_n;
      par       <= par_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = tick ? '0 : cnt + CW'(1);
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    hold_n      = hold;
    hold_full_n = hold_full;
    txd_n       = txd_q;
    par_n       = par;

    if (accept) begin
      hold_n      = TX_DATA;
      hold_full_n = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        txd_n = 1'b1;
        if (hold_full) begin
          state_n     = ST_START;
          shift_n     = hold;
          par_n       = parity_of(hold);
          hold_full_n = 1'b0;
          txd_n       = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
          txd_n     = shift[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              state_n = ST_PARITY;
              txd_n   = par;
            end else begin
              state_n   = ST_STOP;
              bit_cnt_n = '0;
              txd_n     = 1'b1;
            end
          end else begin
            shift_n   = shift >> 1;
            bit_cnt_n = bit_cnt + 3'd1;
            txd_n     = shift[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_n   = ST_STOP;
          bit_cnt_n = '0;
          txd_n     = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            // A word arriving on this very tick bypasses the holding register.
            if (hold_full || accept) begin
              state_n     = ST_START;
              shift_n     = hold_full ? hold : TX_DATA;
              par_n       = parity_of(hold_full ? hold : TX_DATA);
              hold_full_n = 1'b0;
              txd_n       = 1'b0;
            end else begin
              state_n = ST_IDLE;
              txd_n   = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_abfn_uart_1_tx.sv
// Directed bench for abfn_uart_1_tx: four instances cover 8N1 at 434 cycles/bit,
// even and odd parity, and a 5-bit / 2-stop / DIV=2 corner.
module tb_abfn_uart_1_tx;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      tx_valid = '0;
  logic [3:0][7:0] tx_data = '0;
  logic [3:0]      tx_ready;
  logic [3:0]      txd;
  logic [3:0]      tx_busy;
  logic [3:0][2:0] dbg_state;
  int              cyc = 0;
  int              n_checks = 0;
  int              n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: defaults (8N1, DIV 434); 1: even parity DIV 4; 2: odd parity DIV 4;
  // 3: 5 data bits, 2 stop bits, DIV 2.
  abfn_uart_1_tx u_def (
    .CLK(clk), .RESET(rst), .TX_DATA(tx_data[0]), .TX_VALID(tx_valid[0]),
    .TX_READY(tx_ready[0]), .TXD(txd[0]), .TX_BUSY(tx_busy[0]), .dbg_state(dbg_state[0])
  );
  abfn_uart_1_tx #(.BAUD(12500000), .PARITY(2)) u_even (
    .CLK(clk), .RESET(rst), .TX_DATA(tx_data[1]), .TX_VALID(tx_valid[1]),
    .TX_READY(tx_ready[1]), .TXD(txd[1]), .TX_BUSY(tx_busy[1]), .dbg_state(dbg_state[1])
  );
  abfn_uart_1_tx #(.BAUD(12500000), .PARITY(1)) u_odd (
    .CLK(clk), .RESET(rst), .TX_DATA(tx_data[2]), .TX_VALID(tx_valid[2]),
    .TX_READY(tx_ready[2]), .TXD(txd[2]), .TX_BUSY(tx_busy[2]), .dbg_state(dbg_state[2])
  );
  abfn_uart_1_tx #(.BAUD(25000000), .DATA_BITS(5), .STOP_BITS(2)) u_corner (
    .CLK(clk), .RESET(rst), .TX_DATA(tx_data[3][4:0]), .TX_VALID(tx_valid[3]),
    .TX_READY(tx_ready[3]), .TXD(txd[3]), .TX_BUSY(tx_busy[3]), .dbg_state(dbg_state[3])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the instance idle. Returns at the negedge after
  // the start bit's first edge, i.e. sample 0 of the frame.
  task automatic send(input int id, input logic [7:0] data, input string tag);
    check({tag, "_ready_pre"}, 32'(tx_ready[id]), 32'd1);
    tx_valid[id] = 1'b1;
    tx_data[id]  = data;
    @(posedge clk);
    #1;
    tx_valid[id] = 1'b0;
    check({tag, "_ready_after_hs"}, 32'(tx_ready[id]), 32'd0);
    check({tag, "_busy_after_hs"}, 32'(tx_busy[id]), 32'd1);
    @(negedge clk);
    check({tag, "_txd_before_fall"}, 32'(txd[id]), 32'd1);
    @(negedge clk);
    check({tag, "_ready_at_start"}, 32'(tx_ready[id]), 32'd1);
  endtask

  // pat[k] is the expected line level of bit k (k=0 is the start bit).
  // First and last cycle of every bit are checked so each width is exact.
  task automatic check_frame(input int id, input logic [15:0] pat, input int nbits,
                             input int div, input bit idle_after, input string tag);
    for (int n = 0; n < nbits * div; n++) begin
      if ((n % div) == 0 || (n % div) == div - 1)
        check($sformatf("%s_bit%0d_c%0d", tag, n / div, n % div), 32'(txd[id]),
              32'(pat[n / div]));
      if (n == nbits * div - 1)
        check({tag, "_busy_last_cycle"}, 32'(tx_busy[id]), 32'd1);
      @(negedge clk);
    end
    if (idle_after) begin
      check({tag, "_busy_after"}, 32'(tx_busy[id]), 32'd0);
      check({tag, "_txd_after"}, 32'(txd[id]), 32'd1);
      check({tag, "_state_after"}, 32'(dbg_state[id]), 32'd0);
    end
  endtask

  logic [7:0] b2b_words [3];
  int         acc_cyc [3];
  int         guard;

  initial begin
    b2b_words[0] = 8'h11;
    b2b_words[1] = 8'h22;
    b2b_words[2] = 8'h33;

    repeat (3) @(negedge clk);
    check("reset_txd", 32'(txd), 32'hF);
    check("reset_ready", 32'(tx_ready), 32'hF);
    check("reset_busy", 32'(tx_busy), 32'h0);
    check("reset_state0", 32'(dbg_state[0]), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Idle line with TX_VALID low stays high.
    for (int i = 0; i < 6; i++) begin
      check($sformatf("corner_idle_%0d", i), 32'(txd[3]), 32'd1);
      repeat (3) @(negedge clk);
    end

    // Reset during data bit 3 (line bit index 4).
    send(0, 8'hFF, "pre_rst");
    repeat (4 * 434 + 100) @(negedge clk);
    check("mid_frame_state", 32'(dbg_state[0]), 32'd2);
    #3 rst = 1'b1;
    #1;
    check("rst_async_txd", 32'(txd[0]), 32'd1);
    check("rst_async_ready", 32'(tx_ready[0]), 32'd1);
    check("rst_async_busy", 32'(tx_busy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send(0, 8'h3C, "after_rst");
    check_frame(0, 16'h0278, 10, 434, 1'b1, "after_rst_3c");

    // 8N1 0x55: alternating line, busy drops 4340 cycles after the fall.
    send(0, 8'h55, "n81");
    check_frame(0, 16'h02AA, 10, 434, 1'b1, "n81_55");

    // Parity frames, 11 bits x 4 cycles.
    send(1, 8'hA5, "even_a5");
    check_frame(1, 16'h054A, 11, 4, 1'b1, "even_a5");
    send(2, 8'hA5, "odd_a5");
    check_frame(2, 16'h074A, 11, 4, 1'b1, "odd_a5");
    send(1, 8'h01, "even_01");
    check_frame(1, 16'h0602, 11, 4, 1'b1, "even_01");

    // 5 data bits, 2 stop bits, DIV 2.
    send(3, 8'h1F, "corner");
    check_frame(3, 16'h00FE, 8, 2, 1'b1, "corner_1f");

    // Back-to-back through the holding register.
    fork
      begin : b2b_driver
        for (int w = 0; w < 3; w++) begin
          tx_valid[0] = 1'b1;
          tx_data[0]  = b2b_words[w];
          guard = 0;
          while (!tx_ready[0] && guard < 10000) begin
            @(negedge clk);
            guard++;
          end
          check($sformatf("b2b_wait_bound_%0d", w), 32'(guard < 10000), 32'd1);
          @(posedge clk);
          #1 acc_cyc[w] = cyc;
        end
        tx_valid[0] = 1'b0;
      end
      begin : b2b_monitor
        repeat (2) @(negedge clk);
        check_frame(0, 16'h0222, 10, 434, 1'b0, "b2b_11");
        check_frame(0, 16'h0244, 10, 434, 1'b0, "b2b_22");
        check_frame(0, 16'h0266, 10, 434, 1'b1, "b2b_33");
      end
    join
    check("b2b_second_accept", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
    check("b2b_third_accept", 32'(acc_cyc[2] - acc_cyc[0]), 32'd4342);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
